instr_encoder: RTL and testbench

- Inverse of the core's control decoder: accepts decoded instruction fields over a valid/ready handshake and assembles 32-bit RV32I words.
- Supported classes are exactly those the core decodes: lw, sw, R-type, beq, I-type ALU, jal.
- Each legal word is written sequentially into instruction memory through a write port, so test programs can be loaded from a field-level stream.
- Illegal field combinations are rejected with an error code and nothing is written.

---
 rtl/instr_encoder.sv | 170 +++++++++++++++++
 tb/tb_instr_encoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Field-to-word RV32I encoder for the core's subset (lw, sw, R-type, beq, I-ALU, jal).
// Legal words are written sequentially into instruction memory; illegal bundles latch an error.
module instr_encoder #(
  parameter int AW        = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    cls,
  input  logic [2:0]    alu_sel,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [31:0]   imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err,
  output logic [1:0]    err_code
);

  typedef enum logic [1:0] {IDLE, ENC, WR, ERR} state_t;

  state_t              state, state_nxt;
  logic [1:0]          code_q, code_nxt;
  logic [AW-1:0]       addr_q;
  logic [AW:0]         cnt_q;
  logic [31:0]         wdata_q;
  logic                take;
  logic [31:0]         enc_word;
  logic [1:0]          enc_code;

  logic [2:0]          cls_p0, alu_p0;
  logic [4:0]          rd_p0, rs1_p0, rs2_p0;
  logic signed [31:0]  imm_p0;

  function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic alu_legal(input logic [2:0] a);
    return (a == 3'b000) || (a == 3'b001) || (a == 3'b101) || (a == 3'b110) || (a == 3'b010);
  endfunction

  function automatic logic [2:0] alu_f3(input logic [2:0] a);
    case (a)
      3'b101:  return 3'b010;
      3'b110:  return 3'b110;
      3'b010:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  assign in_ready  = (state == IDLE) && !cnt_q[AW];
  assign take      = in_valid && in_ready && !start;
  assign mem_we    = (state == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = cnt_q;
  assign full      = cnt_q[AW];
  assign err       = (state == ERR);
  assign err_code  = code_q;

  // Stage p0: capture the accepted field bundle
  always_ff @(posedge clk) begin
    if (take) begin
      cls_p0 <= cls;
      alu_p0 <= alu_sel;
      rd_p0  <= rd;
      rs1_p0 <= rs1;
      rs2_p0 <= rs2;
      imm_p0 <= imm;
    end
  end

  // Encode and legality check of the captured bundle (consumed in ENC)
  always_comb begin
    enc_word = '0;
    enc_code = 2'b00;
    case (cls_p0)
      3'b000: begin
        enc_word = {imm_p0[11:0], rs1_p0, 3'b010, rd_p0, 7'b0000011};
        if (!in_range(imm_p0, -2048, 2047)) enc_code = 2'b10;
      end
      3'b001: begin
        enc_word = {imm_p0[11:5], rs2_p0, rs1_p0, 3'b010, imm_p0[4:0], 7'b0100011};
        if (!in_range(imm_p0, -2048, 2047)) enc_code = 2'b10;
      end
      3'b010: begin
        enc_word = {(alu_p0 == 3'b001) ? 7'b0100000 : 7'b0000000,
                    rs2_p0, rs1_p0, alu_f3(alu_p0), rd_p0, 7'b0110011};
        if (!alu_legal(alu_p0)) enc_code = 2'b01;
      end
      3'b011: begin
        enc_word = {imm_p0[12], imm_p0[10:5], rs2_p0, rs1_p0, 3'b000,
                    imm_p0[4:1], imm_p0[11], 7'b1100011};
        if (!in_range(imm_p0, -4096, 4094) || imm_p0[0]) enc_code = 2'b10;
      end
      3'b100: begin
        enc_word = {imm_p0[11:0], rs1_p0, alu_f3(alu_p0), rd_p0, 7'b0010011};
        if (!alu_legal(alu_p0) || (alu_p0 == 3'b001)) enc_code = 2'b01;
        else if (!in_range(imm_p0, -2048, 2047))       enc_code = 2'b10;
      end
      3'b101: begin
        enc_word = {imm_p0[20], imm_p0[10:1], imm_p0[11], imm_p0[19:12], rd_p0, 7'b1101111};
        if (!in_range(imm_p0, -1048576, 1048574) || imm_p0[0]) enc_code = 2'b10;
      end
      default: enc_code = 2'b01;
    endcase
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    if (start) begin
      state_nxt = IDLE;
      code_nxt  = 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && cnt_q[AW]) begin
            state_nxt = ERR;
            code_nxt  = 2'b11;
          end else if (take) begin
            state_nxt = ENC;
          end
        end
        ENC: begin
          if (enc_code != 2'b00) begin
            state_nxt = ERR;
            code_nxt  = enc_code;
          end else begin
            state_nxt = WR;
          end
        end
        WR:      state_nxt = IDLE;
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p1: encoded word, write pointer and count
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code_q  <= 2'b00;
      addr_q  <= AW'(BASE_ADDR);
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      if (start) begin
        addr_q <= AW'(BASE_ADDR);
        cnt_q  <= '0;
      end else if (state == WR) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
      if ((state == ENC) && (enc_code == 2'b00)) wdata_q <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder (AW=2 so the full condition is reached often).
module tb_instr_encoder;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    cls = '0;
  logic [2:0]    alu_sel = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0]   imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  logic [1:0]    err_code;

  instr_encoder #(.AW(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .cls(cls), .alu_sel(alu_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
    int          when;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference state of the loader
  int  m_addr = 0;
  int  m_count = 0;
  bit  m_err = 0;
  int  m_code = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Spec-level encoder: field placement by shifts, legality by integer ranges
  function automatic void ref_enc(input int c, input int a, input logic [31:0] r_d,
                                  input logic [31:0] r_s1, input logic [31:0] r_s2, input int im,
                                  output logic [31:0] w, output int code);
    logic [31:0] u;
    logic [31:0] f3;
    bit          alu_ok;
    u = im; w = '0; code = 0; alu_ok = 1; f3 = '0;
    case (a)
      0, 1: f3 = 0;
      5: f3 = 2;
      6: f3 = 6;
      2: f3 = 7;
      default: alu_ok = 0;
    endcase
    case (c)
      0: begin
        if (im < -2048 || im > 2047) code = 2;
        w = (fld(u, 11, 0) << 20) | (r_s1 << 15) | (32'd2 << 12) | (r_d << 7) | 32'h03;
      end
      1: begin
        if (im < -2048 || im > 2047) code = 2;
        w = (fld(u, 11, 5) << 25) | (r_s2 << 20) | (r_s1 << 15) | (32'd2 << 12)
          | (fld(u, 4, 0) << 7) | 32'h23;
      end
      2: begin
        if (!alu_ok) code = 1;
        w = (((a == 1) ? 32'h20 : 32'h0) << 25) | (r_s2 << 20) | (r_s1 << 15) | (f3 << 12)
          | (r_d << 7) | 32'h33;
      end
      3: begin
        if (im < -4096 || im > 4094 || (im % 2) != 0) code = 2;
        w = (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | (r_s2 << 20) | (r_s1 << 15)
          | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7) | 32'h63;
      end
      4: begin
        if (!alu_ok || a == 1) code = 1;
        else if (im < -2048 || im > 2047) code = 2;
        w = (fld(u, 11, 0) << 20) | (r_s1 << 15) | (f3 << 12) | (r_d << 7) | 32'h13;
      end
      5: begin
        if (im < -1048576 || im > 1048574 || (im % 2) != 0) code = 2;
        w = (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20)
          | (fld(u, 19, 12) << 12) | (r_d << 7) | 32'h6F;
      end
      default: code = 1;
    endcase
  endfunction

  function automatic void model_clear();
    m_addr = 0; m_count = 0; m_err = 0; m_code = 0;
  endfunction

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, ".count"},    32'(count),    32'(m_count));
    chk({tag, ".full"},     32'(full),     32'(m_count == CAP));
    chk({tag, ".err"},      32'(err),      32'(m_err));
    chk({tag, ".err_code"}, 32'(err_code), 32'(m_code));
    chk({tag, ".addr"},     32'(mem_addr), 32'(m_addr));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_err && m_count != CAP));
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    check_status("start");
  endtask

  // mode: 0 plain, 1 start during ENC, 2 start with the valid, 3 start during WR
  task automatic send(input int c, input int a, input int r_d, input int r_s1, input int r_s2,
                      input int im, input int mode, input logic [31:0] want);
    logic [31:0] w;
    int          code, acc_cyc;
    bit          acc;
    ref_enc(c, a, 32'(r_d), 32'(r_s1), 32'(r_s2), im, w, code);
    cls = c[2:0]; alu_sel = a[2:0]; rd = r_d[4:0]; rs1 = r_s1[4:0]; rs2 = r_s2[4:0];
    imm = im;
    in_valid = 1'b1;
    if (mode == 2) start = 1'b1;
    @(negedge clk);
    chk("in_ready_pre", 32'(in_ready), 32'(!m_err && m_count != CAP));
    acc = !m_err && (m_count != CAP) && (mode != 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    acc_cyc  = cyc;
    if (mode == 2) begin
      model_clear();
    end else if (!acc) begin
      if (!m_err) begin m_err = 1; m_code = 3; end
    end else if (mode == 1) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_clear();
    end else if (code != 0) begin
      m_err = 1; m_code = code;
    end else begin
      exp_q.push_back('{addr: 32'(m_addr), word: (want != 32'h0) ? want : w, when: acc_cyc + 1});
      m_addr  = (m_addr + 1) % CAP;
      m_count = m_count + 1;
      if (mode == 3) begin
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_status("post");
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr.addr",  32'(mem_addr), e.addr);
        chk("wr.data",  mem_wdata,     e.word);
        chk("wr.cycle", 32'(cyc),      32'(e.when));
      end
    end
  end

  function automatic int rand_imm();
    case ($urandom_range(0, 11))
      0: return -2048;
      1: return 2047;
      2: return 2048;
      3: return -2049;
      4: return 4094;
      5: return -4096;
      6: return 4096;
      7: return -1048576;
      8: return 1048574;
      9: return 1048576;
      10: return int'($urandom_range(0, 8191)) - 4096;
      default: return int'($urandom) >>> 10;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready),  32'd1);
    chk("rst.mem_we",   32'(mem_we),    32'd0);
    chk("rst.addr",     32'(mem_addr),  32'd0);
    chk("rst.wdata",    mem_wdata,      32'd0);
    chk("rst.count",    32'(count),     32'd0);
    chk("rst.full",     32'(full),      32'd0);
    chk("rst.err",      32'(err),       32'd0);
    chk("rst.err_code", 32'(err_code),  32'd0);
    @(posedge clk); #1;

    send(0, 0, 5, 2, 0, 8, 0, 32'h00812283);
    pulse_start();
    send(2, 1, 3, 1, 2, 0, 0, 32'h402081B3);
    send(2, 6, 3, 1, 2, 0, 0, 32'h0020E1B3);
    pulse_start();
    send(3, 0, 0, 1, 2, -4, 0, 32'hFE208EE3);
    send(5, 0, 1, 0, 0, 2048, 0, 32'h001000EF);
    pulse_start();
    send(3, 0, 0, 1, 2, 3, 0, 32'h0);
    pulse_start();
    send(4, 1, 4, 1, 0, 5, 0, 32'h0);
    pulse_start();
    send(1, 0, 0, 2, 6, -1, 0, 32'hFE612FA3);

    // Fill to capacity, then one more bundle
    pulse_start();
    for (int i = 0; i < CAP; i++) send(0, 0, i + 1, 2, 0, 4 * i, 0, 32'h0);
    send(0, 0, 9, 2, 0, 0, 0, 32'h0);

    // start in ENC, with the valid, and during WR
    pulse_start();
    send(0, 0, 1, 1, 0, 0, 0, 32'h0);
    send(0, 0, 2, 2, 0, 4, 1, 32'h0);
    send(4, 0, 7, 3, 0, 1, 0, 32'h0);
    send(0, 0, 2, 2, 0, 4, 2, 32'h0);
    send(2, 2, 8, 9, 10, 0, 3, 32'h0);

    for (int n = 0; n < 250; n++) begin
      int md, r;
      if ((m_err || m_count == CAP) && $urandom_range(0, 2) != 0) pulse_start();
      r  = int'($urandom_range(0, 19));
      md = (r < 3) ? r + 1 : 0;
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rand_imm(), md, 32'h0);
    end

    repeat (5) @(posedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
